// File: rtl/clk_div_ctrl.sv
// Runtime-programmable tick/clock divider with a one-deep pending config.
// New configurations take effect only at a period boundary, so changes are glitch-free.
module clk_div_ctrl #(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 32'd100000,
  parameter int               CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             tick_out,
  output logic             clk_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // Handshake: a config transfers on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready stays low while a config is pending; the offer must be held until taken.
  state_t           state, state_n;
  logic [WIDTH-1:0] counter, counter_n;
  logic [WIDTH-1:0] period_r, period_n;
  logic [CNT_W-1:0] burst_rem, burst_rem_n;
  logic             pend_v, pend_v_n;
  logic [WIDTH-1:0] pend_period, pend_period_n;
  logic [1:0]       pend_mode, pend_mode_n;
  logic [CNT_W-1:0] pend_count, pend_count_n;
  logic             tick_n, clk_out_n, done_n;
  logic [CNT_W-1:0] tick_cnt_n;

  logic             accept;
  logic             apply_now;
  logic [WIDTH-1:0] ap_period;
  logic [1:0]       ap_mode;
  logic [CNT_W-1:0] ap_count;

  assign accept    = cfg_valid && !pend_v;
  assign cfg_ready = !pend_v;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // A pending config always wins over the live inputs as the source to apply.
  assign ap_period = pend_v ? pend_period : cfg_period;
  assign ap_mode   = pend_v ? pend_mode   : cfg_mode;
  assign ap_count  = pend_v ? pend_count  : cfg_count;

  always_comb begin
    state_n       = state;
    counter_n     = counter;
    period_n      = period_r;
    burst_rem_n   = burst_rem;
    pend_v_n      = pend_v;
    pend_period_n = pend_period;
    pend_mode_n   = pend_mode;
    pend_count_n  = pend_count;
    tick_n        = 1'b0;
    done_n        = 1'b0;
    clk_out_n     = clk_out;
    tick_cnt_n    = tick_cnt;
    apply_now     = 1'b0;

    unique case (state)
      S_IDLE: apply_now = pend_v || accept;
      S_RUN, S_BURST: begin
        if (counter == period_r) begin
          tick_n     = 1'b1;
          clk_out_n  = ~clk_out;
          tick_cnt_n = tick_cnt + 1'b1;
          counter_n  = '0;
          if (state == S_BURST) begin
            burst_rem_n = burst_rem - 1'b1;
            if (burst_rem == CNT_W'(1)) begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end
          apply_now = pend_v;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (apply_now) begin
      pend_v_n    = 1'b0;
      period_n    = ap_period;
      burst_rem_n = ap_count;
      counter_n   = '0;
      tick_cnt_n  = '0;
      unique case (ap_mode)
        2'b01: state_n = S_RUN;
        2'b10: begin
          if (ap_count == '0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_BURST;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Accepting while counting parks the config until the next tick edge.
    if (accept && state != S_IDLE) begin
      pend_v_n      = 1'b1;
      pend_period_n = cfg_period;
      pend_mode_n   = cfg_mode;
      pend_count_n  = cfg_count;
    end

    // Deterministic restart phase whenever the controller sits in IDLE.
    if (state_n == S_IDLE) begin
      clk_out_n = 1'b0;
      counter_n = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      counter     <= '0;
      period_r    <= DEFAULT_PERIOD;
      burst_rem   <= '0;
      pend_v      <= 1'b0;
      pend_period <= '0;
      pend_mode   <= 2'b00;
      pend_count  <= '0;
      tick_out    <= 1'b0;
      clk_out     <= 1'b0;
      done        <= 1'b0;
      tick_cnt    <= '0;
    end else begin
      state       <= state_n;
      counter     <= counter_n;
      period_r    <= period_n;
      burst_rem   <= burst_rem_n;
      pend_v      <= pend_v_n;
      pend_period <= pend_period_n;
      pend_mode   <= pend_mode_n;
      pend_count  <= pend_count_n;
      tick_out    <= tick_n;
      clk_out     <= clk_out_n;
      done        <= done_n;
      tick_cnt    <= tick_cnt_n;
    end
  end

endmodule
